// File: rtl/division_issue_queue.sv
// In-order issue buffer in front of the integer divider.
// Holds tagged DIV/REM micro-ops, issues one at a time, returns tagged results.
package division_issue_queue_pkg;
  typedef logic [31:0] data_word_t;
  typedef enum logic [1:0] {
    UOP_DIV,
    UOP_DIVU,
    UOP_REM,
    UOP_REMU
  } div_uop_t;
endpackage

module division_issue_queue
  import division_issue_queue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clk_en_i,
  input  logic                 flush_i,
  input  logic                 data_valid_i,
  input  data_word_t           dividend_i,
  input  data_word_t           divisor_i,
  input  div_uop_t             operation_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 ready_o,
  output data_word_t           div_dividend_o,
  output data_word_t           div_divisor_o,
  output div_uop_t             div_operation_o,
  output logic                 div_data_valid_o,
  input  logic                 div_idle_i,
  input  logic                 div_data_valid_i,
  input  data_word_t           div_result_i,
  input  logic                 div_divide_by_zero_i,
  output data_word_t           result_o,
  output logic [TAG_WIDTH-1:0] result_tag_o,
  output logic                 result_valid_o,
  output logic                 divide_by_zero_o,
  output logic                 busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    data_word_t           dividend;
    data_word_t           divisor;
    div_uop_t             op;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  entry_t               mem [DEPTH];
  entry_t               head;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic [AW:0]          count_nxt;
  state_t               state;
  state_t               state_nxt;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 kill;
  logic                 push;
  logic                 pop;

  assign head = mem[rd_ptr];
  assign push = data_valid_i & ready_o & ~flush_i;
  assign pop  = (state == S_IDLE) & (count != '0)
              & div_idle_i & ~flush_i;

  always_comb begin
    count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    if (flush_i) count_nxt = '0;
    state_nxt = state;
    case (state)
      S_IDLE: if (pop) state_nxt = S_WAIT;
      S_WAIT: if (div_data_valid_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Storage needs no reset: count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (clk_en_i && push) begin
      mem[wr_ptr] <= '{dividend_i, divisor_i, operation_i, tag_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      state            <= S_IDLE;
      tag_q            <= '0;
      kill             <= 1'b0;
      ready_o          <= 1'b1;
      busy_o           <= 1'b0;
      div_dividend_o   <= '0;
      div_divisor_o    <= '0;
      div_operation_o  <= UOP_DIV;
      div_data_valid_o <= 1'b0;
      result_o         <= '0;
      result_tag_o     <= '0;
      result_valid_o   <= 1'b0;
      divide_by_zero_o <= 1'b0;
    end else if (clk_en_i) begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      div_data_valid_o <= pop;
      if (pop) begin
        div_dividend_o  <= head.dividend;
        div_divisor_o   <= head.divisor;
        div_operation_o <= head.op;
        tag_q           <= head.tag;
        kill            <= 1'b0;
      end
      if (flush_i && state == S_WAIT) kill <= 1'b1;
      result_valid_o <= 1'b0;
      if (state == S_WAIT && div_data_valid_i) begin
        result_o         <= div_result_i;
        divide_by_zero_o <= div_divide_by_zero_i;
        result_tag_o     <= tag_q;
        result_valid_o   <= ~kill & ~flush_i;
      end
      state   <= state_nxt;
      count   <= count_nxt;
      ready_o <= count_nxt != FULL;
      busy_o  <= (count_nxt != '0) | (state_nxt == S_WAIT);
    end
  end

endmodule
